// File: rtl/slot_game_core.sv
// Slot-machine game engine: credit bookkeeping, bet debit, staggered N-reel spin and payout.
// Single clocked FSM IDLE -> SPIN -> PAYOUT -> IDLE with saturating money arithmetic.
module slot_game_core #(
  parameter int unsigned NUM_REELS  = 3,
  parameter int unsigned SYM_W      = 3,
  parameter int unsigned MONEY_W    = 11,
  parameter int unsigned BET        = 1,
  parameter int unsigned SPIN_TICKS = 4,
  parameter int unsigned MULT_ALL   = 10,
  parameter int unsigned MULT_PAIR  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_en,
  input  logic                       add_pulse,
  input  logic                       gamble_pulse,
  input  logic                       cash_out_pulse,
  input  logic [1:0]                 denom_sel,
  input  logic [NUM_REELS*SYM_W-1:0] rand_in,
  output logic [MONEY_W-1:0]         balance,
  output logic [MONEY_W-1:0]         invested,
  output logic [NUM_REELS*SYM_W-1:0] reels,
  output logic [NUM_REELS-1:0]       spinning,
  output logic [1:0]                 state,
  output logic                       win,
  output logic [MONEY_W-1:0]         last_payout
);

  localparam int unsigned CntW = $clog2(SPIN_TICKS * NUM_REELS + 1);

  localparam logic [MONEY_W-1:0] MaxVal  = '1;
  localparam logic [MONEY_W-1:0] BetV    = MONEY_W'(BET);
  localparam logic [MONEY_W-1:0] PayAll  = MONEY_W'(BET * MULT_ALL);
  localparam logic [MONEY_W-1:0] PayPair = MONEY_W'(BET * MULT_PAIR);

  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StSpin   = 2'b01;
  localparam logic [1:0] StPayout = 2'b10;

  if (longint'(BET) * longint'(MULT_ALL) > (longint'(1) << MONEY_W) - 1) begin : g_bad_cfg
    $error("slot_game_core: BET*MULT_ALL does not fit in MONEY_W bits");
  end

  logic [1:0]                 state_q, state_d;
  logic [MONEY_W-1:0]         bal_q, bal_d;
  logic [MONEY_W-1:0]         inv_q, inv_d;
  logic [MONEY_W-1:0]         last_q, last_d;
  logic [NUM_REELS*SYM_W-1:0] reels_q, reels_d;
  logic [NUM_REELS-1:0]       spin_q, spin_d;
  logic [CntW-1:0]            cnt_q, cnt_d;

  logic [CntW-1:0]    cnt_inc;
  logic [MONEY_W-1:0] denom, headroom, credit, payout, bal_pay, inv_add;
  logic [MONEY_W:0]   pay_sum, inv_sum;
  logic               all_eq, any_pair;

  // Payout is evaluated from the frozen reel registers.
  always_comb begin
    all_eq   = 1'b1;
    any_pair = 1'b0;
    for (int i = 1; i < int'(NUM_REELS); i++) begin
      if (reels_q[i*SYM_W +: SYM_W] != reels_q[0 +: SYM_W]) all_eq = 1'b0;
      if (reels_q[i*SYM_W +: SYM_W] == reels_q[(i-1)*SYM_W +: SYM_W]) any_pair = 1'b1;
    end
    if (all_eq)        payout = PayAll;
    else if (any_pair) payout = PayPair;
    else               payout = '0;
  end

  always_comb begin
    unique case (denom_sel)
      2'b00:   denom = MONEY_W'(5);
      2'b01:   denom = MONEY_W'(10);
      2'b10:   denom = MONEY_W'(20);
      default: denom = '0;
    endcase
    headroom = MaxVal - bal_q;
    credit   = (denom < headroom) ? denom : headroom;
    inv_sum  = {1'b0, inv_q} + {1'b0, credit};
    inv_add  = inv_sum[MONEY_W] ? MaxVal : inv_sum[MONEY_W-1:0];
    pay_sum  = {1'b0, bal_q} + {1'b0, payout};
    bal_pay  = pay_sum[MONEY_W] ? MaxVal : pay_sum[MONEY_W-1:0];
    cnt_inc  = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    inv_d   = inv_q;
    last_d  = last_q;
    reels_d = reels_q;
    spin_d  = spin_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (cash_out_pulse) begin
          bal_d = '0;
          inv_d = '0;
        end else if (gamble_pulse) begin
          if (bal_q >= BetV) begin
            bal_d   = bal_q - BetV;
            spin_d  = '1;
            cnt_d   = '0;
            state_d = StSpin;
          end
        end else if (add_pulse) begin
          bal_d = bal_q + credit;
          inv_d = inv_add;
        end
      end
      StSpin: begin
        if (tick_en) cnt_d = cnt_inc;
        // Spinning reels animate every cycle; a reel's stop cycle also loads, then it holds.
        for (int i = 0; i < int'(NUM_REELS); i++) begin
          if (spin_q[i]) begin
            reels_d[i*SYM_W +: SYM_W] = rand_in[i*SYM_W +: SYM_W];
            if (tick_en && (cnt_inc == CntW'(SPIN_TICKS * (i + 1)))) spin_d[i] = 1'b0;
          end
        end
        if (tick_en && (cnt_inc == CntW'(SPIN_TICKS * NUM_REELS))) state_d = StPayout;
      end
      StPayout: begin
        last_d  = payout;
        bal_d   = bal_pay;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bal_q   <= '0;
      inv_q   <= '0;
      last_q  <= '0;
      reels_q <= '0;
      spin_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      inv_q   <= inv_d;
      last_q  <= last_d;
      reels_q <= reels_d;
      spin_q  <= spin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign balance     = bal_q;
  assign invested    = inv_q;
  assign reels       = reels_q;
  assign spinning    = spin_q;
  assign state       = state_q;
  assign last_payout = last_q;
  assign win         = (state_q == StPayout) && (payout != '0);

endmodule

// File: tb/tb_slot_game_core.sv
// Directed bench for slot_game_core: money handling, spin staging, payouts and reset.
module tb_slot_game_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_en, add_pulse, gamble_pulse, cash_out_pulse;
  logic [1:0]  denom_sel;
  logic [8:0]  rand_in;
  logic [10:0] balance, invested, last_payout;
  logic [8:0]  reels;
  logic [2:0]  spinning;
  logic [1:0]  state;
  logic        win;

  int n_tests = 0;
  int n_fail  = 0;

  slot_game_core dut (
    .clk            (clk),
    .rst            (rst),
    .tick_en        (tick_en),
    .add_pulse      (add_pulse),
    .gamble_pulse   (gamble_pulse),
    .cash_out_pulse (cash_out_pulse),
    .denom_sel      (denom_sel),
    .rand_in        (rand_in),
    .balance        (balance),
    .invested       (invested),
    .reels          (reels),
    .spinning       (spinning),
    .state          (state),
    .win            (win),
    .last_payout    (last_payout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [1:0] d);
    denom_sel = d; add_pulse = 1'b1; cyc(); add_pulse = 1'b0;
  endtask

  task automatic do_gamble();
    gamble_pulse = 1'b1; cyc(); gamble_pulse = 1'b0;
  endtask

  task automatic do_cash();
    cash_out_pulse = 1'b1; cyc(); cash_out_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_en = 1'b1; cyc(); tick_en = 1'b0;
    end
  endtask

  task automatic load15();
    do_cash();
    for (int k = 0; k < 3; k++) do_add(2'b00);
  endtask

  initial begin
    rst = 1'b1; tick_en = 1'b0; add_pulse = 1'b0; gamble_pulse = 1'b0;
    cash_out_pulse = 1'b0; denom_sel = 2'b00; rand_in = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_balance", balance, 0);
    chk("rst_state", state, 0);
    chk("rst_spinning", spinning, 0);

    // 1: three 5-credit inserts, then a no-op denomination
    for (int k = 0; k < 3; k++) do_add(2'b00);
    chk("t1_balance", balance, 15);
    chk("t1_invested", invested, 15);
    chk("t1_state", state, 0);
    do_add(2'b11);
    chk("t1_none_balance", balance, 15);

    // 2: saturation at 2047
    do_cash();
    for (int k = 0; k < 102; k++) do_add(2'b10);
    chk("t2_balance_2040", balance, 2040);
    do_add(2'b10);
    chk("t2_balance_sat", balance, 2047);
    chk("t2_invested_sat", invested, 2047);
    do_add(2'b10);
    chk("t2_balance_hold", balance, 2047);
    chk("t2_invested_hold", invested, 2047);

    // 3: gamble with empty balance is ignored
    do_cash();
    do_gamble();
    chk("t3_state", state, 0);
    chk("t3_spinning", spinning, 0);
    chk("t3_balance", balance, 0);

    // 4: jackpot, all reels 5
    load15();
    rand_in = 9'b101_101_101;
    do_gamble();
    chk("t4_state_spin", state, 1);
    chk("t4_spinning", spinning, 3'b111);
    chk("t4_balance_debit", balance, 14);
    ticks(2);
    do_add(2'b00);
    chk("t4_add_ignored", balance, 14);
    ticks(2);
    chk("t4_spin_4", spinning, 3'b110);
    ticks(4);
    chk("t4_spin_8", spinning, 3'b100);
    ticks(4);
    chk("t4_spin_12", spinning, 3'b000);
    chk("t4_state_payout", state, 2);
    chk("t4_win_high", win, 1);
    cyc();
    chk("t4_last_payout", last_payout, 10);
    chk("t4_balance", balance, 24);
    chk("t4_win_low", win, 0);
    chk("t4_state_idle", state, 0);

    // 5a: no match
    load15();
    rand_in = {3'd3, 3'd2, 3'd1};
    do_gamble();
    ticks(12);
    chk("t5a_state_payout", state, 2);
    chk("t5a_win", win, 0);
    cyc();
    chk("t5a_last_payout", last_payout, 0);
    chk("t5a_balance", balance, 14);

    // 5b: pair; reel 0 must hold after it stops while rand_in moves on
    load15();
    rand_in = {3'd6, 3'd4, 3'd4};
    do_gamble();
    ticks(4);
    rand_in = {3'd6, 3'd4, 3'd7};
    ticks(8);
    chk("t5b_reels", reels, 9'b110_100_100);
    chk("t5b_win", win, 1);
    cyc();
    chk("t5b_last_payout", last_payout, 2);
    chk("t5b_balance", balance, 16);

    // 6: reset mid-spin, then cash_out beats add
    load15();
    do_gamble();
    ticks(6);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_balance", balance, 0);
    chk("t6_invested", invested, 0);
    chk("t6_reels", reels, 0);
    chk("t6_spinning", spinning, 0);
    chk("t6_state", state, 0);
    chk("t6_win", win, 0);
    chk("t6_last_payout", last_payout, 0);
    do_add(2'b01);
    chk("t6_add10", balance, 10);
    denom_sel = 2'b01; add_pulse = 1'b1; cash_out_pulse = 1'b1;
    cyc();
    add_pulse = 1'b0; cash_out_pulse = 1'b0;
    chk("t6_prio_balance", balance, 0);
    chk("t6_prio_invested", invested, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
